// File: rtl/matmul_tile_scheduler.sv
// Tile-loop sequencer for a blocked C = A x B.
// Walks (i, l, r) tile coordinates with i outer, l middle and r inner. For each tile step it
// handshakes in turn with the A fetch, B fetch, multiply and accumulate units.
// All loop state lives here, so the datapath can stay stateless.
// Optional feature: define SCHED_TIMEOUT_EN to add a per-phase watchdog. When it fires, the
// scheduler aborts to IDLE with err set.
module matmul_tile_scheduler #(
  parameter int unsigned M           = 4,
  parameter int unsigned N           = 4,
  parameter int unsigned P           = 4,
  parameter int unsigned TM          = 2,
  parameter int unsigned TK          = 2,
  parameter int unsigned TN          = 2,
  parameter int unsigned IDX_W       = 10,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             a_req,
  input  logic             a_done,
  output logic             b_req,
  input  logic             b_done,
  output logic             mul_req,
  input  logic             mul_done,
  output logic             acc_req,
  input  logic             acc_done,
  output logic [IDX_W-1:0] row_off,
  output logic [IDX_W-1:0] k_off,
  output logic [IDX_W-1:0] col_off,
  output logic             first_k,
  output logic             last_k
);

  // Elaboration-time sanity checks on the tiling.
  if ((M % TM) != 0 || (P % TK) != 0 || (N % TN) != 0) begin : g_bad_tiling
    $error("matmul_tile_scheduler: matrix dimensions must be multiples of the tile extents");
  end
  if ((M >> IDX_W) != 0 || (N >> IDX_W) != 0 || (P >> IDX_W) != 0) begin : g_bad_idx_w
    $error("matmul_tile_scheduler: IDX_W too narrow for the matrix dimensions");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("matmul_tile_scheduler: TIMEOUT_CYC must be at least 1");
  end

  localparam logic [IDX_W-1:0] RowLast = IDX_W'(M - TM);
  localparam logic [IDX_W-1:0] ColLast = IDX_W'(N - TN);
  localparam logic [IDX_W-1:0] KLast   = IDX_W'(P - TK);
  localparam logic [IDX_W-1:0] RowStep = IDX_W'(TM);
  localparam logic [IDX_W-1:0] ColStep = IDX_W'(TN);
  localparam logic [IDX_W-1:0] KStep   = IDX_W'(TK);

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StMul,
    StAcc,
    StNext,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             a_req_q, a_req_d;
  logic             b_req_q, b_req_d;
  logic             mul_req_q, mul_req_d;
  logic             acc_req_q, acc_req_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             first_k_q, first_k_d;
  logic             last_k_q, last_k_d;
  logic             last_tile;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic            err_q, err_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  // Next-state and next-output decode for the whole sequencer.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    a_req_d   = a_req_q;
    b_req_d   = b_req_q;
    mul_req_d = mul_req_q;
    acc_req_d = acc_req_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    first_k_d = first_k_q;
    last_k_d  = last_k_q;
    last_tile = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    err_d     = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StGetA;
          busy_d    = 1'b1;
          a_req_d   = 1'b1;
          row_d     = '0;
          col_d     = '0;
          k_d       = '0;
          first_k_d = 1'b1;
          last_k_d  = (KLast == '0);
`ifdef SCHED_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      StGetA: begin
        if (a_done && a_req_q) begin
          state_d = StGetB;
          a_req_d = 1'b0;
          b_req_d = 1'b1;
        end
      end
      StGetB: begin
        if (b_done && b_req_q) begin
          state_d   = StMul;
          b_req_d   = 1'b0;
          mul_req_d = 1'b1;
        end
      end
      StMul: begin
        if (mul_done && mul_req_q) begin
          state_d   = StAcc;
          mul_req_d = 1'b0;
          acc_req_d = 1'b1;
        end
      end
      StAcc: begin
        if (acc_done && acc_req_q) begin
          state_d   = StNext;
          acc_req_d = 1'b0;
        end
      end
      StNext: begin
        // r is innermost, then l, then i; all three wrap to zero on the final tile.
        if (k_q == KLast) begin
          k_d = '0;
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d     = '0;
              last_tile = 1'b1;
            end else begin
              row_d = row_q + RowStep;
            end
          end else begin
            col_d = col_q + ColStep;
          end
        end else begin
          k_d = k_q + KStep;
        end

        if (last_tile) begin
          state_d   = StDone;
          done_d    = 1'b1;
          first_k_d = 1'b0;
          last_k_d  = 1'b0;
        end else begin
          state_d   = StGetA;
          a_req_d   = 1'b1;
          first_k_d = (k_d == '0);
          last_k_d  = (k_d == KLast);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef SCHED_TIMEOUT_EN
    // A phase that has waited its full budget and is still stalled aborts the run.
    if ((state_d == state_q) && (state_q inside {StGetA, StGetB, StMul, StAcc}) &&
        (tmo_q == TmoLast)) begin
      state_d   = StDone;
      done_d    = 1'b1;
      err_d     = 1'b1;
      a_req_d   = 1'b0;
      b_req_d   = 1'b0;
      mul_req_d = 1'b0;
      acc_req_d = 1'b0;
    end

    // The counter restarts on every state entry and idles at zero.
    if ((state_d != state_q) || (state_q == StIdle)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
`endif
  end

  // Single state register holding the FSM state, the handshake requests and the coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_req_q   <= 1'b0;
      b_req_q   <= 1'b0;
      mul_req_q <= 1'b0;
      acc_req_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      first_k_q <= 1'b0;
      last_k_q  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      err_q     <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_req_q   <= a_req_d;
      b_req_q   <= b_req_d;
      mul_req_q <= mul_req_d;
      acc_req_q <= acc_req_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      first_k_q <= first_k_d;
      last_k_q  <= last_k_d;
`ifdef SCHED_TIMEOUT_EN
      err_q     <= err_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a_req   = a_req_q;
  assign b_req   = b_req_q;
  assign mul_req = mul_req_q;
  assign acc_req = acc_req_q;
  assign row_off = row_q;
  assign col_off = col_q;
  assign k_off   = k_q;
  assign first_k = first_k_q;
  assign last_k  = last_k_q;

`ifdef SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler at default dimensions (4x4x4, 2x2x2 tiles).
module tb_matmul_tile_scheduler;

  localparam int unsigned IdxW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy, done, err;
  logic            a_req, b_req, mul_req, acc_req;
  logic            a_done, b_done, mul_done, acc_done;
  logic [IdxW-1:0] row_off, k_off, col_off;
  logic            first_k, last_k;

  matmul_tile_scheduler #(
    .M(4), .N(4), .P(4), .TM(2), .TK(2), .TN(2), .IDX_W(IdxW), .TIMEOUT_CYC(16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .a_req    (a_req),
    .a_done   (a_done),
    .b_req    (b_req),
    .b_done   (b_done),
    .mul_req  (mul_req),
    .mul_done (mul_done),
    .acc_req  (acc_req),
    .acc_done (acc_done),
    .row_off  (row_off),
    .k_off    (k_off),
    .col_off  (col_off),
    .first_k  (first_k),
    .last_k   (last_k)
  );

  always #5 clk = ~clk;

  // Responder: 0 manual, 1 all dones held high, 2 done one cycle after req, 3 as 1 minus mul.
  int         mode_sel = 0;
  logic [3:0] man_v    = '0;
  logic [3:0] seen_v   = '0;
  logic [3:0] auto_v   = '0;
  logic [3:0] req_v;
  logic [3:0] done_v;

  assign req_v  = {a_req, b_req, mul_req, acc_req};
  assign done_v = (mode_sel == 0) ? man_v :
                  (mode_sel == 2) ? auto_v :
                  (mode_sel == 3) ? 4'b1101 : 4'b1111;
  assign {a_done, b_done, mul_done, acc_done} = done_v;

  always @(negedge clk) seen_v = req_v;
  always @(posedge clk) begin
    #1;
    auto_v = seen_v & req_v;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int row;
    int col;
    int k;
    int fk;
    int lk;
  } step_t;

  typedef struct {
    int mode;
    int poke;
    int exp_done_cyc;
  } run_t;

  step_t steps[8];
  run_t  runs[3];

  // Runs one full multiply. Cycle 0 is the cycle in which start is high.
  task automatic run_full(input int mode, input int poke, input int exp_cyc);
    int cyc, step, ndone, dcyc;
    logic prev_a, prev_acc;
    mode_sel = mode;
    step = 0; ndone = 0; dcyc = -1; prev_a = 1'b0; prev_acc = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (cyc < 400 && (ndone == 0 || cyc <= dcyc + 3)) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("busy_after_start", int'(busy), 1);
        check("err_clear_after_start", int'(err), 0);
      end
      if (a_req && !prev_a) begin
        if (step < 8) begin
          check($sformatf("row_step%0d", step), int'(row_off), steps[step].row);
          check($sformatf("col_step%0d", step), int'(col_off), steps[step].col);
          check($sformatf("k_step%0d", step), int'(k_off), steps[step].k);
          check($sformatf("first_k_step%0d", step), int'(first_k), steps[step].fk);
          check($sformatf("last_k_step%0d", step), int'(last_k), steps[step].lk);
        end
        step++;
      end
      if (acc_req && !prev_acc && step > 0 && step <= 8) begin
        check($sformatf("hold_step%0d", step - 1),
              int'(row_off) * 10000 + int'(col_off) * 100 + int'(k_off),
              steps[step-1].row * 10000 + steps[step-1].col * 100 + steps[step-1].k);
        check($sformatf("hold_flags_step%0d", step - 1), int'({first_k, last_k}),
              steps[step-1].fk * 2 + steps[step-1].lk);
      end
      prev_a = a_req;
      prev_acc = acc_req;
      if (done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = cyc;
          check("busy_in_done", int'(busy), 1);
          check("err_normal_done", int'(err), 0);
        end
      end
      if (ndone > 0 && cyc == dcyc + 1) check("busy_after_done", int'(busy), 0);
      if (ndone > 0 && cyc == dcyc + 3) check("no_auto_restart", int'(a_req), 0);
      @(posedge clk); #1;
      cyc++;
      start = (poke != 0) && (cyc == 12);
    end
    start = 1'b0;
    check("step_count", step, 8);
    check("done_cycle", dcyc, exp_cyc);
    check("done_pulses", ndone, 1);
  endtask

  initial begin
    logic found;
    int   mulcnt, dcyc, errd;

    steps[0] = '{0, 0, 0, 1, 0};
    steps[1] = '{0, 0, 2, 0, 1};
    steps[2] = '{0, 2, 0, 1, 0};
    steps[3] = '{0, 2, 2, 0, 1};
    steps[4] = '{2, 0, 0, 1, 0};
    steps[5] = '{2, 0, 2, 0, 1};
    steps[6] = '{2, 2, 0, 1, 0};
    steps[7] = '{2, 2, 2, 0, 1};
    // 5 cycles/step with dones held high, 9 with one-cycle-late dones: done at 1 + 8*step.
    runs[0] = '{1, 0, 41};
    runs[1] = '{2, 1, 73};
    runs[2] = '{1, 1, 41};

    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy_done_err", int'({busy, done, err}), 0);
    check("reset_reqs", int'(req_v), 0);
    check("reset_offsets", int'(row_off) + int'(col_off) + int'(k_off), 0);
    check("reset_first_last", int'({first_k, last_k}), 0);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_full(runs[i].mode, runs[i].poke, runs[i].exp_done_cyc);
    end

    // Stray b_done during GET_A, then b_done already high on GET_B entry.
    mode_sel = 0;
    man_v = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    man_v = 4'b0100;
    @(posedge clk); #1 man_v = 4'b0000;
    @(negedge clk);
    check("stray_b_a_req", int'(a_req), 1);
    check("stray_b_b_req", int'(b_req), 0);
    @(posedge clk); #1 man_v = 4'b1100;
    @(posedge clk); #1 man_v = 4'b0100;
    @(negedge clk);
    check("getb_entry_reqs", int'(req_v), 4'b0100);
    @(posedge clk); #1 man_v = 4'b0000;
    @(negedge clk);
    check("prehigh_b_accepted", int'(req_v), 4'b0010);
    check("prehigh_offsets", int'(row_off) + int'(col_off) + int'(k_off), 0);
    rst = 1'b0;
    #2 rst = 1'b1;

    // Reset during the MUL phase of step (2,0,2).
    mode_sel = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (mul_req && row_off == 2 && col_off == 0 && k_off == 2) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reach_mul_2_0_2", int'(found), 1);
    rst = 1'b0;
    #1;
    check("midrst_busy_done_err", int'({busy, done, err}), 0);
    check("midrst_reqs", int'(req_v), 0);
    check("midrst_offsets", int'(row_off) + int'(col_off) + int'(k_off), 0);
    check("midrst_first_last", int'({first_k, last_k}), 0);
    @(posedge clk); #1 rst = 1'b1;
    run_full(1, 0, 41);

`ifdef SCHED_TIMEOUT_EN
    // mul_done never returned: mul_req high cycles 3..18, abort DONE in cycle 19.
    mode_sel = 3;
    mulcnt = 0; dcyc = -1; errd = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (mul_req) mulcnt++;
      if (done && dcyc < 0) begin
        dcyc = c;
        errd = int'(err);
      end
      if (c == 23) begin
        check("tmo_err_sticky", int'(err), 1);
        check("tmo_idle_busy", int'(busy), 0);
      end
      @(posedge clk); #1;
    end
    check("tmo_mul_req_cycles", mulcnt, 16);
    check("tmo_done_cycle", dcyc, 19);
    check("tmo_err_at_done", errd, 1);
    run_full(1, 0, 41);
`else
    mulcnt = 0; dcyc = 0; errd = 0;
    check("err_tied_low", int'(err) + mulcnt + dcyc + errd, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
